// File: rtl/nest_cnt_pkg.sv
// Shared constants for the nested-loop counter and the fitness-evaluation controller.
package nest_cnt_pkg;

    localparam int unsigned DEF_N_CH      = 3;
    localparam int unsigned DEF_CNT_WIDTH = 4;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_STOP = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : nest_cnt_pkg

// File: rtl/nest_loop_counter_if.sv
// Control/status bundle of the nested-loop counter.
// dir_i exists only when NEST_CNT_DOWN_EN is defined.
interface nest_loop_counter_if #(
    parameter int unsigned N_CH      = nest_cnt_pkg::DEF_N_CH,
    parameter int unsigned CNT_WIDTH = nest_cnt_pkg::DEF_CNT_WIDTH
);

    localparam int unsigned BUS_W = N_CH * CNT_WIDTH;

    logic             clr_i;
    logic             en_i;
    logic [BUS_W-1:0] lim_i;
    logic             mode_i;
`ifdef NEST_CNT_DOWN_EN
    logic             dir_i;
`endif
    logic [BUS_W-1:0] cnt_o;
    logic [N_CH-1:0]  tc_o;
    logic             last_o;
    logic             done_o;
    logic             stop_o;

`ifdef NEST_CNT_DOWN_EN
    modport master (
        output clr_i, en_i, lim_i, mode_i, dir_i,
        input  cnt_o, tc_o, last_o, done_o, stop_o
    );
    modport slave (
        input  clr_i, en_i, lim_i, mode_i, dir_i,
        output cnt_o, tc_o, last_o, done_o, stop_o
    );
`else
    modport master (
        output clr_i, en_i, lim_i, mode_i,
        input  cnt_o, tc_o, last_o, done_o, stop_o
    );
    modport slave (
        input  clr_i, en_i, lim_i, mode_i,
        output cnt_o, tc_o, last_o, done_o, stop_o
    );
`endif

endinterface : nest_loop_counter_if

// File: rtl/nest_cnt_stage.sv
// One counter channel: index and limit registers, terminal detect, step on carry_i.
module nest_cnt_stage
    import nest_cnt_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clr_i,
    input  logic                 clr_dir_i,
    input  logic                 dir_i,
    input  logic [CNT_WIDTH-1:0] lim_i,
    input  logic                 carry_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 tc_c,
    output logic                 tc_nxt_c
);

    logic [CNT_WIDTH-1:0] lim_q;
    logic [CNT_WIDTH-1:0] start_c;
    logic [CNT_WIDTH-1:0] term_c;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Terminal detect on current and next index; next index reloads at terminal.
    always_comb begin
        start_c  = '0;
        term_c   = lim_q;
        if (dir_i == DIR_DOWN) begin
            start_c = lim_q;
            term_c  = '0;
        end
        tc_c  = (cnt_o == term_c);
        cnt_d = cnt_o;
        if (carry_i) begin
            if (tc_c)                   cnt_d = start_c;
            else if (dir_i == DIR_DOWN) cnt_d = cnt_o - CNT_WIDTH'(1);
            else                        cnt_d = cnt_o + CNT_WIDTH'(1);
        end
        tc_nxt_c = (cnt_d == term_c);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_o <= '0;
            lim_q <= '0;
        end else if (clr_i) begin
            lim_q <= lim_i;
            cnt_o <= (clr_dir_i == DIR_DOWN) ? lim_i : '0;
        end else begin
            cnt_o <= cnt_d;
        end
    end

endmodule : nest_cnt_stage

// File: rtl/nest_loop_counter.sv
// Multi-channel odometer-style loop counter with runtime limits, wrap/stop mode and done pulse.
// Optional down-counting is enabled by defining NEST_CNT_DOWN_EN.
module nest_loop_counter
    import nest_cnt_pkg::*;
#(
    parameter int unsigned N_CH      = DEF_N_CH,
    parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
    input logic                clk_i,
    input logic                rst_n_i,
    nest_loop_counter_if.slave bus
);

    logic            mode_q;
    logic            done_q;
    logic            stop_q;
    logic            dir_c;
    logic            clr_dir_c;
    logic [N_CH-1:0] tc_c;
    logic [N_CH-1:0] tc_nxt_c;
    logic [N_CH-1:0] carry_c;
    logic            last_c;
    logic            step_c;
    logic            hold_c;
    logic            adv_c;
    logic            enter_last_c;
    logic            done_d;
    logic            stop_d;

`ifdef NEST_CNT_DOWN_EN
    logic dir_q;
    assign dir_c     = dir_q;
    assign clr_dir_c = bus.dir_i;
`else
    assign dir_c     = DIR_UP;
    assign clr_dir_c = DIR_UP;
`endif

    assign last_c = &tc_c;
    assign step_c = bus.en_i & ~bus.clr_i & ~stop_q;
    // In stop mode a step from the all-terminal state is absorbed instead of wrapping.
    assign hold_c = step_c & (mode_q == MODE_STOP) & last_c;
    assign adv_c  = step_c & ~hold_c;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        if (k == 0) begin : g_first
            assign carry_c[k] = adv_c;
        end else begin : g_next
            assign carry_c[k] = adv_c & (&tc_c[k-1:0]);
        end

        nest_cnt_stage #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_stage (
            .clk_i     (clk_i),
            .rst_n_i   (rst_n_i),
            .clr_i     (bus.clr_i),
            .clr_dir_i (clr_dir_c),
            .dir_i     (dir_c),
            .lim_i     (bus.lim_i[k*CNT_WIDTH +: CNT_WIDTH]),
            .carry_i   (carry_c[k]),
            .cnt_o     (bus.cnt_o[k*CNT_WIDTH +: CNT_WIDTH]),
            .tc_c      (tc_c[k]),
            .tc_nxt_c  (tc_nxt_c[k])
        );
    end

    assign enter_last_c = adv_c & ~last_c & (&tc_nxt_c);

    // Completion: wrap out of the final index, or arrival at it when stopping.
    always_comb begin
        done_d = 1'b0;
        stop_d = stop_q;
        if (mode_q == MODE_STOP) begin
            done_d = hold_c | enter_last_c;
            stop_d = stop_q | done_d;
        end else begin
            done_d = adv_c & last_c;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mode_q <= MODE_WRAP;
            done_q <= 1'b0;
            stop_q <= 1'b0;
`ifdef NEST_CNT_DOWN_EN
            dir_q  <= DIR_UP;
`endif
        end else if (bus.clr_i) begin
            mode_q <= bus.mode_i;
            done_q <= 1'b0;
            stop_q <= 1'b0;
`ifdef NEST_CNT_DOWN_EN
            dir_q  <= bus.dir_i;
`endif
        end else begin
            done_q <= done_d;
            stop_q <= stop_d;
        end
    end

    assign bus.tc_o   = tc_c;
    assign bus.last_o = last_c;
    assign bus.done_o = done_q;
    assign bus.stop_o = stop_q;

endmodule : nest_loop_counter

// File: tb/tb_nest_loop_counter.sv
// Directed bench for nest_loop_counter (3 channels x 4 bits); down-count case under NEST_CNT_DOWN_EN.
module tb_nest_loop_counter;

    localparam int unsigned N_CH = 3;
    localparam int unsigned CW   = 4;
    localparam int unsigned W    = N_CH * CW;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    nest_loop_counter_if #(.N_CH(N_CH), .CNT_WIDTH(CW)) bus ();

    nest_loop_counter #(.N_CH(N_CH), .CNT_WIDTH(CW)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    function automatic logic [W-1:0] pk(input int c2, input int c1, input int c0);
        return {4'(c2), 4'(c1), 4'(c0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr(input logic [W-1:0] lim, input logic mode);
        bus.clr_i  = 1'b1;
        bus.en_i   = 1'b0;
        bus.lim_i  = lim;
        bus.mode_i = mode;
        tick();
        bus.clr_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        n_tests++; if (bus.cnt_o !== pk(0,0,0)) begin n_fail++; $display("FAIL reset_cnt: got %h expected %h", bus.cnt_o, pk(0,0,0)); end
        n_tests++; if (bus.tc_o !== 3'b111) begin n_fail++; $display("FAIL reset_tc: got %b expected 111", bus.tc_o); end
        n_tests++; if (bus.done_o !== 1'b0 || bus.stop_o !== 1'b0) begin n_fail++; $display("FAIL reset_flags: done %b stop %b expected 0 0", bus.done_o, bus.stop_o); end
        do_clr(pk(2,1,3), 1'b0);
        bus.en_i = 1'b1;
        repeat (5) tick();
        n_tests++; if (bus.cnt_o !== pk(0,1,1)) begin n_fail++; $display("FAIL midcount_cnt: got %h expected %h", bus.cnt_o, pk(0,1,1)); end
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++; if (bus.cnt_o !== pk(0,0,0)) begin n_fail++; $display("FAIL rerst_cnt: got %h expected %h", bus.cnt_o, pk(0,0,0)); end
        n_tests++; if (bus.done_o !== 1'b0 || bus.stop_o !== 1'b0) begin n_fail++; $display("FAIL rerst_flags: done %b stop %b expected 0 0", bus.done_o, bus.stop_o); end
        n_tests++; if (bus.tc_o !== 3'b111) begin n_fail++; $display("FAIL rerst_tc: got %b expected 111", bus.tc_o); end
        rst_n    = 1'b1;
        bus.en_i = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        int e;
        do_clr(pk(2,1,3), 1'b0);
        n_tests++; if (bus.cnt_o !== pk(0,0,0) || bus.tc_o !== 3'b000) begin n_fail++; $display("FAIL wrap_start: cnt %h tc %b expected 000 000", bus.cnt_o, bus.tc_o); end
        bus.en_i = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            e = i % 24;
            n_tests++; if (bus.cnt_o !== pk(e/8, (e/4)%2, e%4)) begin n_fail++; $display("FAIL wrap_cnt step %0d: got %h expected %h", i, bus.cnt_o, pk(e/8, (e/4)%2, e%4)); end
            n_tests++; if (bus.done_o !== (i == 24)) begin n_fail++; $display("FAIL wrap_done step %0d: got %b expected %b", i, bus.done_o, (i == 24)); end
            if (i == 23) begin
                n_tests++; if (bus.last_o !== 1'b1) begin n_fail++; $display("FAIL wrap_last: got %b expected 1", bus.last_o); end
            end
        end
        bus.en_i = 1'b0;
        tick();
        n_tests++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL wrap_done_drop: got %b expected 0", bus.done_o); end
    endtask

    task automatic test_stop();
        int e;
        do_clr(pk(2,1,3), 1'b1);
        bus.en_i = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            e = (i < 23) ? i : 23;
            n_tests++; if (bus.cnt_o !== pk(e/8, (e/4)%2, e%4)) begin n_fail++; $display("FAIL stop_cnt step %0d: got %h expected %h", i, bus.cnt_o, pk(e/8, (e/4)%2, e%4)); end
            n_tests++; if (bus.done_o !== (i == 23)) begin n_fail++; $display("FAIL stop_done step %0d: got %b expected %b", i, bus.done_o, (i == 23)); end
            n_tests++; if (bus.stop_o !== (i >= 23)) begin n_fail++; $display("FAIL stop_flag step %0d: got %b expected %b", i, bus.stop_o, (i >= 23)); end
        end
        do_clr(pk(2,1,3), 1'b1);
        n_tests++; if (bus.stop_o !== 1'b0 || bus.cnt_o !== pk(0,0,0)) begin n_fail++; $display("FAIL stop_clr: stop %b cnt %h expected 0 000", bus.stop_o, bus.cnt_o); end
    endtask

    task automatic test_clr_en();
        do_clr(pk(0,0,7), 1'b0);
        bus.en_i = 1'b1;
        repeat (5) tick();
        n_tests++; if (bus.cnt_o !== pk(0,0,5)) begin n_fail++; $display("FAIL clren_pre: got %h expected %h", bus.cnt_o, pk(0,0,5)); end
        bus.clr_i = 1'b1;
        bus.lim_i = pk(1,1,2);
        tick();
        bus.clr_i = 1'b0;
        bus.lim_i = pk(0,0,0);
        n_tests++; if (bus.cnt_o !== pk(0,0,0)) begin n_fail++; $display("FAIL clren_cnt: got %h expected %h", bus.cnt_o, pk(0,0,0)); end
        repeat (3) tick();
        n_tests++; if (bus.cnt_o !== pk(0,1,0)) begin n_fail++; $display("FAIL clren_newlim: got %h expected %h", bus.cnt_o, pk(0,1,0)); end
        n_tests++; if (bus.tc_o !== 3'b010) begin n_fail++; $display("FAIL clren_tc: got %b expected 010", bus.tc_o); end
        bus.en_i = 1'b0;
        tick();
    endtask

    task automatic test_zero_lim();
        int   exp_c1 [3] = '{1, 2, 0};
        logic exp_dn [3] = '{1'b0, 1'b0, 1'b1};
        do_clr(pk(0,2,0), 1'b0);
        n_tests++; if (bus.tc_o !== 3'b101) begin n_fail++; $display("FAIL zlim_tc0: got %b expected 101", bus.tc_o); end
        bus.en_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (bus.cnt_o !== pk(0, exp_c1[i], 0)) begin n_fail++; $display("FAIL zlim_cnt step %0d: got %h expected %h", i+1, bus.cnt_o, pk(0, exp_c1[i], 0)); end
            n_tests++; if (bus.tc_o[0] !== 1'b1) begin n_fail++; $display("FAIL zlim_tc step %0d: got %b expected 1", i+1, bus.tc_o[0]); end
            n_tests++; if (bus.done_o !== exp_dn[i]) begin n_fail++; $display("FAIL zlim_done step %0d: got %b expected %b", i+1, bus.done_o, exp_dn[i]); end
        end
        bus.en_i = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        do_clr(pk(0,0,0), 1'b0);
        n_tests++; if (bus.last_o !== 1'b1) begin n_fail++; $display("FAIL b2b_last: got %b expected 1", bus.last_o); end
        bus.en_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (bus.done_o !== 1'b1 || bus.cnt_o !== pk(0,0,0)) begin n_fail++; $display("FAIL b2b_done step %0d: done %b cnt %h expected 1 000", i+1, bus.done_o, bus.cnt_o); end
        end
        bus.en_i = 1'b0;
        tick();
        n_tests++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b expected 0", bus.done_o); end
    endtask

`ifdef NEST_CNT_DOWN_EN
    task automatic test_down();
        int   exp_c1 [6] = '{1, 1, 0, 0, 0, 1};
        int   exp_c0 [6] = '{1, 0, 2, 1, 0, 2};
        logic exp_dn [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.dir_i = 1'b1;
        do_clr(pk(0,1,2), 1'b0);
        n_tests++; if (bus.cnt_o !== pk(0,1,2)) begin n_fail++; $display("FAIL down_start: got %h expected %h", bus.cnt_o, pk(0,1,2)); end
        n_tests++; if (bus.tc_o !== 3'b100) begin n_fail++; $display("FAIL down_tc: got %b expected 100", bus.tc_o); end
        bus.en_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tests++; if (bus.cnt_o !== pk(0, exp_c1[i], exp_c0[i])) begin n_fail++; $display("FAIL down_cnt step %0d: got %h expected %h", i+1, bus.cnt_o, pk(0, exp_c1[i], exp_c0[i])); end
            n_tests++; if (bus.done_o !== exp_dn[i]) begin n_fail++; $display("FAIL down_done step %0d: got %b expected %b", i+1, bus.done_o, exp_dn[i]); end
        end
        bus.en_i  = 1'b0;
        bus.dir_i = 1'b0;
        tick();
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        bus.clr_i  = 1'b0;
        bus.en_i   = 1'b0;
        bus.lim_i  = '0;
        bus.mode_i = 1'b0;
`ifdef NEST_CNT_DOWN_EN
        bus.dir_i  = 1'b0;
`endif
        test_reset();
        test_wrap();
        test_stop();
        test_clr_en();
        test_zero_lim();
        test_back_to_back();
`ifdef NEST_CNT_DOWN_EN
        test_down();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_nest_loop_counter
